// File: rtl/fm_sweep_pkg.sv
// Shared widths, default sizes and FSM encoding for the FM hop-sweep controller.
package fm_sweep_pkg;
  localparam int DEPTH_DEF = 8;
  localparam int DW_W_DEF  = 16;
  localparam int FC_W      = 24;
  localparam int FD_W      = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/fm_hop_table.sv
// Hop table: one write port, one combinational read port, cleared by reset.
module fm_hop_table
  import fm_sweep_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW_W  = DW_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [FC_W-1:0]          wr_fc,
  input  logic [FD_W-1:0]          wr_fd,
  input  logic [DW_W-1:0]          wr_dwell,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [FC_W-1:0]          rd_fc,
  output logic [FD_W-1:0]          rd_fd,
  output logic [DW_W-1:0]          rd_dwell
);
  logic [FC_W-1:0] fc_mem    [DEPTH];
  logic [FD_W-1:0] fd_mem    [DEPTH];
  logic [DW_W-1:0] dwell_mem [DEPTH];

  // Flop-based rather than block RAM: the whole table must clear on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fc_mem[i]    <= '0;
        fd_mem[i]    <= '0;
        dwell_mem[i] <= '0;
      end
    end else if (we) begin
      fc_mem[wr_addr]    <= wr_fc;
      fd_mem[wr_addr]    <= wr_fd;
      dwell_mem[wr_addr] <= wr_dwell;
    end
  end

  assign rd_fc    = fc_mem[rd_addr];
  assign rd_fd    = fd_mem[rd_addr];
  assign rd_dwell = dwell_mem[rd_addr];
endmodule

// File: rtl/fm_sweep_ctrl.sv
// Steps fc/fd through a programmable hop table, holding each entry for its dwell count.
module fm_sweep_ctrl
  import fm_sweep_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW_W  = DW_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [FC_W-1:0]          cfg_fc,
  input  logic [FD_W-1:0]          cfg_fd,
  input  logic [DW_W-1:0]          cfg_dwell,
  input  logic [$clog2(DEPTH)-1:0] last_idx,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     stop,
  output logic [FC_W-1:0]          fc,
  output logic [FD_W-1:0]          fd,
  output logic [$clog2(DEPTH)-1:0] hop_idx,
  output logic                     hop_strobe,
  output logic                     busy,
  output logic                     done
);
  localparam int AW = $clog2(DEPTH);

  state_t          state_reg, state_next;
  logic [FC_W-1:0] fc_reg, fc_next;
  logic [FD_W-1:0] fd_reg, fd_next;
  logic [AW-1:0]   idx_reg, idx_next;
  logic            strobe_reg, strobe_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic [DW_W-1:0] cnt_reg, cnt_next;
  logic [AW-1:0]   last_reg, last_next;
  logic            loop_reg, loop_next;

  logic [AW-1:0]   rd_addr;
  logic [FC_W-1:0] tbl_fc;
  logic [FD_W-1:0] tbl_fd;
  logic [DW_W-1:0] tbl_dwell;
  logic            load;

  fm_hop_table #(
    .DEPTH(DEPTH),
    .DW_W (DW_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (cfg_we && (state_reg == ST_IDLE)),
    .wr_addr (cfg_addr),
    .wr_fc   (cfg_fc),
    .wr_fd   (cfg_fd),
    .wr_dwell(cfg_dwell),
    .rd_addr (rd_addr),
    .rd_fc   (tbl_fc),
    .rd_fd   (tbl_fd),
    .rd_dwell(tbl_dwell)
  );

  // The read port always points at whichever entry the next load would take.
  assign rd_addr = (state_reg == ST_RUN && idx_reg < last_reg) ? idx_reg + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      fc_reg     <= '0;
      fd_reg     <= '0;
      idx_reg    <= '0;
      strobe_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      cnt_reg    <= '0;
      last_reg   <= '0;
      loop_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      fc_reg     <= fc_next;
      fd_reg     <= fd_next;
      idx_reg    <= idx_next;
      strobe_reg <= strobe_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      cnt_reg    <= cnt_next;
      last_reg   <= last_next;
      loop_reg   <= loop_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    fc_next     = fc_reg;
    fd_next     = fd_reg;
    idx_next    = idx_reg;
    strobe_next = 1'b0;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    cnt_next    = cnt_reg;
    last_next   = last_reg;
    loop_next   = loop_reg;
    load        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start && !stop) begin
          load       = 1'b1;
          last_next  = last_idx;
          loop_next  = loop_en;
          state_next = ST_RUN;
          busy_next  = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end else if (cnt_reg == '0) begin
          if (idx_reg < last_reg || loop_reg) begin
            load = 1'b1;
          end else begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase

    // Counter holds the cycles remaining after the load cycle; dwell 0 behaves as 1.
    if (load) begin
      fc_next     = tbl_fc;
      fd_next     = tbl_fd;
      idx_next    = rd_addr;
      strobe_next = 1'b1;
      cnt_next    = (tbl_dwell == '0) ? '0 : tbl_dwell - 1'b1;
    end
  end

  assign fc         = fc_reg;
  assign fd         = fd_reg;
  assign hop_idx    = idx_reg;
  assign hop_strobe = strobe_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
endmodule

// File: tb/tb_fm_sweep_ctrl.sv
// Self-checking bench for fm_sweep_ctrl: expected traces are expanded from the hop table contents.
module tb_fm_sweep_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [23:0] cfg_fc = '0;
  logic [15:0] cfg_fd = '0;
  logic [15:0] cfg_dwell = '0;
  logic [2:0]  last_idx = '0;
  logic        loop_en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [23:0] fc;
  logic [15:0] fd;
  logic [2:0]  hop_idx;
  logic        hop_strobe, busy, done;

  int n_checks = 0;
  int n_fail = 0;

  logic [23:0] m_fc [8];
  logic [15:0] m_fd [8];
  int          m_dw [8];

  fm_sweep_ctrl #(.DEPTH(8), .DW_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_fc(cfg_fc),
    .cfg_fd(cfg_fd), .cfg_dwell(cfg_dwell), .last_idx(last_idx), .loop_en(loop_en),
    .start(start), .stop(stop), .fc(fc), .fd(fd), .hop_idx(hop_idx),
    .hop_strobe(hop_strobe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input logic [23:0] f, input logic [15:0] d,
                             input int w, input bit upd);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_fc = f; cfg_fd = d; cfg_dwell = 16'(w);
    tick();
    cfg_we = 1'b0;
    if (upd) begin
      m_fc[a] = f; m_fd[a] = d; m_dw[a] = w;
    end
  endtask

  task automatic check_out(input string name, input int cyc, input logic [45:0] exp_v);
    logic [45:0] obs;
    obs = {fc, fd, hop_idx, hop_strobe, busy, done};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got fc=%0d fd=%0d idx=%0d stb=%0d busy=%0d done=%0d exp fc=%0d fd=%0d idx=%0d stb=%0d busy=%0d done=%0d",
               name, cyc, obs[45:22], obs[21:6], obs[5:3], obs[2], obs[1], obs[0],
               exp_v[45:22], exp_v[21:6], exp_v[5:3], exp_v[2], exp_v[1], exp_v[0]);
    end
  endtask

  // Expand the table into a per-cycle trace, start a sweep, and follow it cycle by cycle.
  task automatic run_sweep(input string name, input int last, input bit lp,
                           input int max_cyc, input int stop_at);
    int q_idx[$];
    bit q_stb[$];
    int sa, i;
    do begin
      for (int e = 0; e <= last; e++) begin
        int n = (m_dw[e] == 0) ? 1 : m_dw[e];
        for (int j = 0; j < n; j++) begin
          q_idx.push_back(e);
          q_stb.push_back(j == 0);
        end
      end
    end while (lp && q_idx.size() < max_cyc);
    sa = stop_at;
    if (sa >= q_idx.size()) sa = -1;
    if (lp && sa < 0) sa = q_idx.size() - 1;

    last_idx = 3'(last); loop_en = lp; start = 1'b1;
    tick();
    start = 1'b0;
    last_idx = 3'($urandom_range(0, 7));
    loop_en = ~lp;
    for (int k = 0; k < q_idx.size(); k++) begin
      i = q_idx[k];
      check_out(name, k, {m_fc[i], m_fd[i], 3'(i), q_stb[k], 1'b1, 1'b0});
      if (k == sa) begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_out({name, "_stop"}, k + 1, {m_fc[i], m_fd[i], 3'(i), 3'b000});
        tick();
        check_out({name, "_idle"}, k + 2, {m_fc[i], m_fd[i], 3'(i), 3'b000});
        $display("sweep %s last=%0d loop=%0d stopped after %0d cycles", name, last, lp, k + 1);
        return;
      end
      tick();
    end
    check_out({name, "_done"}, q_idx.size(), {m_fc[last], m_fd[last], 3'(last), 3'b001});
    tick();
    check_out({name, "_post"}, q_idx.size() + 1, {m_fc[last], m_fd[last], 3'(last), 3'b000});
    $display("sweep %s last=%0d loop=%0d completed in %0d cycles", name, last, lp, q_idx.size());
  endtask

  task automatic load_basic();
    write_entry(0, 24'd1000, 16'd100, 3, 1'b1);
    write_entry(1, 24'd2000, 16'd200, 2, 1'b1);
    write_entry(2, 24'd3000, 16'd300, 1, 1'b1);
  endtask

  task automatic test_reset();
    for (int e = 0; e < 8; e++) begin
      m_fc[e] = '0; m_fd[e] = '0; m_dw[e] = 0;
    end
    rst = 1'b0;
    tick(); tick();
    check_out("reset_held", 0, '0);
    rst = 1'b1;
    tick();
    check_out("reset_released", 1, '0);
    $display("reset: outputs checked during and after reset");
  endtask

  task automatic test_start_stop_same();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_out("start_stop_idle", 0, '0);
    tick();
    check_out("start_stop_idle2", 1, '0);
    $display("start+stop in idle: no sweep begun");
  endtask

  task automatic test_basic();
    run_sweep("basic", 2, 1'b0, 0, -1);
  endtask

  task automatic test_loop();
    run_sweep("loop", 2, 1'b1, 14, 13);
  endtask

  task automatic test_stop_at_expiry();
    run_sweep("stop_expiry", 2, 1'b0, 0, 2);
  endtask

  task automatic test_dwell_zero();
    write_entry(0, 24'd1000, 16'd100, 0, 1'b1);
    run_sweep("dwell_zero", 0, 1'b0, 0, -1);
    write_entry(0, 24'd1000, 16'd100, 3, 1'b1);
  endtask

  task automatic test_write_busy();
    last_idx = 3'd2; loop_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    write_entry(1, 24'd5555, 16'd1, 9, 1'b0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_busy_state got busy=%0d exp busy=1", busy);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    run_sweep("after_busy_write", 2, 1'b0, 0, -1);
  endtask

  task automatic test_reset_mid();
    last_idx = 3'd2; loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (hop_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL reset_mid_setup got idx=%0d exp idx=1", hop_idx);
    end
    #2;
    rst = 1'b0;
    #1;
    check_out("reset_async", 0, '0);
    tick(); tick();
    check_out("reset_no_done", 2, '0);
    rst = 1'b1;
    for (int e = 0; e < 8; e++) begin
      m_fc[e] = '0; m_fd[e] = '0; m_dw[e] = 0;
    end
    tick();
    run_sweep("after_reset", 2, 1'b0, 0, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int last, st;
      bit lp;
      for (int e = 0; e < 8; e++)
        write_entry(e, 24'($urandom), 16'($urandom), $urandom_range(0, 4), 1'b1);
      last = $urandom_range(0, 7);
      lp = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 30) : -1;
      run_sweep($sformatf("rand%0d", it), last, lp, 24, st);
    end
  endtask

  initial begin
    test_reset();
    load_basic();
    test_start_stop_same();
    test_basic();
    test_loop();
    test_stop_at_expiry();
    test_dwell_zero();
    test_write_busy();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fm_sweep_ctrl.md
FM_SWEEP_CTRL -- requirements
Module: fm_sweep_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning hop-table entries (power of 2).
REQ-002 SHALL have parameter DW_W, default 16, meaning dwell-count width.
REQ-003 SHALL have port clk, input, 1, system clock (only clock).
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cfg_we, input, 1, hop-table write enable.
REQ-006 SHALL have port cfg_addr, input, log2(DEPTH), table write address.
REQ-007 SHALL have port cfg_fc, input, 24, carrier frequency word to write.
REQ-008 SHALL have port cfg_fd, input, 16, deviation word to write.
REQ-009 SHALL have port cfg_dwell, input, DW_W, dwell cycles to write.
REQ-010 SHALL have port last_idx, input, log2(DEPTH), index of final hop.
REQ-011 SHALL have port loop_en, input, 1, wrap to entry 0 after last hop.
REQ-012 SHALL have port start, input, 1, begin sweep.
REQ-013 SHALL have port stop, input, 1, abort sweep.
REQ-014 SHALL have port fc, output, 24, frequency word to the FM datapath.
REQ-015 SHALL have port fd, output, 16, deviation word to the FM datapath.
REQ-016 SHALL have port hop_idx, output, log2(DEPTH), entry currently driven.
REQ-017 SHALL have port hop_strobe, output, 1, one-cycle pulse when fc/fd load a new entry.
REQ-018 SHALL have port busy, output, 1, sweep in progress.
REQ-019 SHALL have port done, output, 1, one-cycle pulse at normal completion.

Function
REQ-020 SHALL implement states IDLE and RUN; all outputs registered.
REQ-021 SHALL accept cfg_we writes only in IDLE; writes while busy ignored, table unchanged.
REQ-022 SHALL, on start in IDLE at cycle T, at T+1 drive entry 0 on fc/fd, hop_idx=0, hop_strobe=1, busy=1, and latch last_idx and loop_en for the whole sweep.
REQ-023 SHALL hold each entry for exactly max(dwell,1) cycles; dwell=0 treated as 1.
REQ-024 SHALL, on dwell expiry with hop_idx<last_idx, drive entry hop_idx+1 in the next cycle with hop_strobe=1 (no gap cycle).
REQ-025 SHALL, on expiry at last_idx with loop_en latched 1, wrap to entry 0 with hop_strobe=1.
REQ-026 SHALL, on expiry at last_idx with loop_en latched 0, go to IDLE next cycle: busy=0, done=1 for one cycle, fc/fd/hop_idx hold last values.
REQ-027 SHALL, on stop in RUN, go to IDLE next cycle: busy=0, done=0, fc/fd hold.
REQ-028 SHALL give stop priority over start and over dwell expiry in the same cycle.
REQ-029 SHALL ignore start while busy.
REQ-030 SHALL treat fc/fd as unsigned/two's-complement pass-through, no arithmetic applied.

Reset
REQ-031 SHALL, on rst low, asynchronously clear fc, fd, hop_idx, hop_strobe, busy, done, dwell counter and all table entries to 0, state IDLE.
REQ-032 SHALL, on reset mid-sweep, abort without a done pulse; first start after release runs from entry 0.

Structure
REQ-033 SHALL place DEPTH/DW_W defaults, state encodings and the 24/16 word widths in package fm_sweep_pkg.
REQ-034 SHALL implement the table as sub-module fm_hop_table (register file, synchronous write, combinational read).

Verification
REQ-035 SHALL verify: entries {fc=1000,fd=100,dw=3},{2000,200,2},{3000,300,1}, last_idx=2, loop_en=0, start -> fc 1000x3, 2000x2, 3000x1 cycles, 3 strobes, done one cycle after, busy 6 cycles.
REQ-036 SHALL verify: same table, loop_en=1 -> sequence repeats 1000,2000,3000,1000...; no done; stop -> busy=0 next cycle, fc holds.
REQ-037 SHALL verify: entry 0 dw=0, last_idx=0, loop_en=0 -> fc held 1 cycle, done next cycle.
REQ-038 SHALL verify: start and stop same cycle in IDLE -> busy stays 0; stop and expiry same cycle -> no next-entry strobe.
REQ-039 SHALL verify: cfg_we to addr 1 with fc=5555 while busy -> later sweep still drives 2000 at index 1.
REQ-040 SHALL verify: rst low during hop 1 -> all outputs 0 immediately, no done; restart begins at entry 0 with fc=0 (table cleared).
